// File: rtl/sam_con_mc.sv
// Multi-channel ternary-kernel 1-D convolution engine.
// One sample stream fills a sliding window of up to MAX_K taps. N_CH ternary kernels
// ({+1, 0, -1}) are applied to that window in parallel, with a configurable stride.
// Optional feature macro: SAM_CON_SAT_EN. When it is defined, results are clamped to the
// DATA_W signed range and flagged on Out_Sat. Otherwise results wrap and Out_Sat is 0.
module sam_con_mc #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned MAX_K  = 16,
  parameter int unsigned N_CH   = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     Start,
  input  logic [CNT_W-1:0]         Ksize_Cfg,
  input  logic [CNT_W-1:0]         Stride_Cfg,
  output logic                     Cfg_Err,
  input  logic                     Kern_Valid,
  input  logic [2*N_CH-1:0]        Kern_In,
  input  logic [DATA_W-1:0]        In_Data,
  input  logic                     In_Valid,
  input  logic                     In_Last,
  output logic                     In_Ready,
  output logic [N_CH*DATA_W-1:0]   Out_Data,
  output logic [N_CH-1:0]          Out_Sat,
  output logic                     Out_Valid,
  input  logic                     Out_Ready,
  output logic                     Out_Last,
  output logic                     Done,
  output logic                     Busy
);

`ifdef SAM_CON_SAT_EN
  // Wide enough that a MAX_K-tap sum never overflows before the clamp.
  localparam int unsigned SumW = DATA_W + $clog2(MAX_K) + 1;
  localparam logic signed [SumW-1:0] SatMax = {{(SumW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SumW-1:0] SatMin = ~SatMax;
`else
  // Low DATA_W bits of a modular sum equal the truncated wide sum, so wrap needs no extra bits.
  localparam int unsigned SumW = DATA_W;
`endif

  typedef enum logic [1:0] {StIdle, StKload, StRun, StDrain} state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_k;
  logic [CNT_W-1:0]        r_s;
  logic [CNT_W-1:0]        r_tcnt;
  logic [CNT_W-1:0]        r_fill;
  logic [CNT_W-1:0]        r_ph;
  // r_win[0] is the newest sample; r_tap[j] is the tap applied to r_win[j].
  logic [DATA_W-1:0]       r_win [MAX_K];
  logic [2*N_CH-1:0]       r_tap [MAX_K];
  logic [DATA_W-1:0]       r_out_data [N_CH];
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_done;
  logic                    r_cfg_err;

  logic                    w_accept;
  logic                    w_complete;
  logic                    w_cfg_ok;
  logic [DATA_W-1:0]       w_win_nxt [MAX_K];
  logic signed [SumW-1:0]  w_sum [N_CH];
  logic [DATA_W-1:0]       w_res [N_CH];

  assign In_Ready  = (r_state == StRun) && (!r_out_valid || Out_Ready);
  assign w_accept  = In_Valid && In_Ready;
  assign w_cfg_ok  = (Ksize_Cfg != '0) && (Ksize_Cfg <= CNT_W'(MAX_K)) && (Stride_Cfg != '0);
  // Window full before this sample: stride phase decides; otherwise the K-th sample completes.
  assign w_complete = (r_fill == r_k) ? (r_ph + CNT_W'(1) == r_s) : (r_fill + CNT_W'(1) == r_k);

  // Window as it will look once the incoming sample is shifted in.
  always_comb begin
    w_win_nxt[0] = In_Data;
    for (int j = 1; j < int'(MAX_K); j++) begin
      w_win_nxt[j] = r_win[j-1];
    end
  end

  // Ternary multiply-accumulate per channel; taps beyond K are zero so the full window is summed.
  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      w_sum[c] = '0;
      for (int j = 0; j < int'(MAX_K); j++) begin
        if (r_tap[j][2*c +: 2] == 2'b01) begin
          w_sum[c] = w_sum[c] + SumW'($signed(w_win_nxt[j]));
        end else if (r_tap[j][2*c +: 2] == 2'b11) begin
          w_sum[c] = w_sum[c] - SumW'($signed(w_win_nxt[j]));
        end
      end
    end
  end

`ifdef SAM_CON_SAT_EN
  logic [N_CH-1:0] w_sat;
  logic [N_CH-1:0] r_out_sat;

  // Clamp each channel to the signed DATA_W range and flag it.
  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      w_sat[c] = 1'b0;
      w_res[c] = w_sum[c][DATA_W-1:0];
      if (w_sum[c] > SatMax) begin
        w_sat[c] = 1'b1;
        w_res[c] = SatMax[DATA_W-1:0];
      end else if (w_sum[c] < SatMin) begin
        w_sat[c] = 1'b1;
        w_res[c] = SatMin[DATA_W-1:0];
      end
    end
  end

  // Saturation flags travel with the result they describe.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_out_sat <= '0;
    end else if (r_state == StRun && w_accept && w_complete) begin
      r_out_sat <= w_sat;
    end
  end

  assign Out_Sat = r_out_sat;
`else
  // Plain two's-complement wrap.
  always_comb begin
    for (int c = 0; c < int'(N_CH); c++) begin
      w_res[c] = w_sum[c];
    end
  end

  assign Out_Sat = '0;
`endif

  // Control FSM with registered result, handshake and status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state     <= StIdle;
      r_k         <= '0;
      r_s         <= '0;
      r_tcnt      <= '0;
      r_fill      <= '0;
      r_ph        <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_cfg_err   <= 1'b0;
      for (int j = 0; j < int'(MAX_K); j++) begin
        r_win[j] <= '0;
        r_tap[j] <= '0;
      end
      for (int c = 0; c < int'(N_CH); c++) begin
        r_out_data[c] <= '0;
      end
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (r_out_valid && Out_Ready) begin
        r_out_valid <= 1'b0;
      end
      unique case (r_state)
        StIdle: begin
          if (Start) begin
            if (w_cfg_ok) begin
              r_k     <= Ksize_Cfg;
              r_s     <= Stride_Cfg;
              r_tcnt  <= '0;
              r_fill  <= '0;
              r_ph    <= '0;
              r_state <= StKload;
              for (int j = 0; j < int'(MAX_K); j++) begin
                r_win[j] <= '0;
                r_tap[j] <= '0;
              end
            end else begin
              r_cfg_err <= 1'b1;
            end
          end
        end
        StKload: begin
          if (Kern_Valid) begin
            // Tap t pairs with the oldest-but-t sample, i.e. window slot K-1-t.
            for (int j = 0; j < int'(MAX_K); j++) begin
              if (j == int'(r_k) - 1 - int'(r_tcnt)) begin
                r_tap[j] <= Kern_In;
              end
            end
            r_tcnt <= r_tcnt + CNT_W'(1);
            if (r_tcnt == r_k - CNT_W'(1)) begin
              r_state <= StRun;
            end
          end
        end
        StRun: begin
          if (w_accept) begin
            for (int j = 0; j < int'(MAX_K); j++) begin
              r_win[j] <= w_win_nxt[j];
            end
            if (r_fill != r_k) begin
              r_fill <= r_fill + CNT_W'(1);
            end
            if (w_complete) begin
              r_ph        <= '0;
              r_out_valid <= 1'b1;
              r_out_last  <= In_Last;
              for (int c = 0; c < int'(N_CH); c++) begin
                r_out_data[c] <= w_res[c];
              end
            end else if (r_fill == r_k) begin
              r_ph <= r_ph + CNT_W'(1);
            end
            // Acceptance implies any older result handshakes now, so only a new one can pend.
            if (In_Last) begin
              if (w_complete) begin
                r_state <= StDrain;
              end else begin
                r_state <= StIdle;
                r_done  <= 1'b1;
              end
            end
          end
        end
        StDrain: begin
          if (!r_out_valid || Out_Ready) begin
            r_state <= StIdle;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Pack per-channel results onto the output bus.
  always_comb begin
    Out_Data = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      Out_Data[c*DATA_W +: DATA_W] = r_out_data[c];
    end
  end

  assign Out_Valid = r_out_valid;
  assign Out_Last  = r_out_last;
  assign Done      = r_done;
  assign Cfg_Err   = r_cfg_err;
  assign Busy      = (r_state != StIdle);

endmodule

// File: tb/tb_sam_con_mc.sv
// Directed testbench for sam_con_mc (DATA_W=8 so the overflow case is reachable).
// Inputs change on the falling edge; a monitor records every output handshake.
module tb_sam_con_mc;
  localparam int DW = 8;
  localparam int MK = 16;
  localparam int NC = 4;
  localparam int CW = 8;

  logic            Clk = 1'b0;
  logic            Rst;
  logic            Start;
  logic [CW-1:0]   Ksize_Cfg;
  logic [CW-1:0]   Stride_Cfg;
  logic            Cfg_Err;
  logic            Kern_Valid;
  logic [2*NC-1:0] Kern_In;
  logic [DW-1:0]   In_Data;
  logic            In_Valid;
  logic            In_Last;
  logic            In_Ready;
  logic [NC*DW-1:0] Out_Data;
  logic [NC-1:0]   Out_Sat;
  logic            Out_Valid;
  logic            Out_Ready;
  logic            Out_Last;
  logic            Done;
  logic            Busy;

  typedef struct {
    logic [7:0] d0;
    logic [7:0] d1;
    logic       last;
    logic       sat0;
  } res_t;

  res_t q[$];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_cnt = 0;

  sam_con_mc #(.DATA_W(DW), .MAX_K(MK), .N_CH(NC), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Ksize_Cfg(Ksize_Cfg), .Stride_Cfg(Stride_Cfg),
    .Cfg_Err(Cfg_Err), .Kern_Valid(Kern_Valid), .Kern_In(Kern_In), .In_Data(In_Data),
    .In_Valid(In_Valid), .In_Last(In_Last), .In_Ready(In_Ready), .Out_Data(Out_Data),
    .Out_Sat(Out_Sat), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Last(Out_Last),
    .Done(Done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Monitor: sample mid-cycle, after inputs settle and before the next rising edge.
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (!Rst && Out_Valid && Out_Ready) begin
        q.push_back('{d0: Out_Data[7:0], d1: Out_Data[15:8], last: Out_Last, sat0: Out_Sat[0]});
      end
      if (!Rst && Done) done_cnt++;
    end
  end

  task automatic start_run(input int k, input int s);
    Start = 1'b1;
    Ksize_Cfg = CW'(k);
    Stride_Cfg = CW'(s);
    @(negedge Clk);
    Start = 1'b0;
  endtask

  task automatic load_tap(input logic [2*NC-1:0] v);
    Kern_Valid = 1'b1;
    Kern_In = v;
    @(negedge Clk);
    Kern_Valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int   guard = 0;
    logic acc = 1'b0;
    In_Data = d;
    In_Valid = 1'b1;
    In_Last = last;
    while (!acc) begin
      #4;
      if (In_Ready) acc = 1'b1;
      @(negedge Clk);
      guard++;
      if (!acc && guard > 60) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_timeout: sample %0d not accepted, In_Ready=%0b required 1", d, In_Ready);
        break;
      end
    end
    In_Valid = 1'b0;
    In_Last = 1'b0;
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    Start = 1'b0; Ksize_Cfg = '0; Stride_Cfg = '0; Kern_Valid = 1'b0; Kern_In = '0;
    In_Data = '0; In_Valid = 1'b0; In_Last = 1'b0; Out_Ready = 1'b1;
    repeat (2) @(negedge Clk);
    #1;
    n_tests++;
    if ({Out_Data, Out_Sat, Out_Valid, Out_Last, In_Ready, Cfg_Err, Done, Busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got data=%h sat=%b v=%b l=%b rdy=%b err=%b done=%b busy=%b, want 0",
               Out_Data, Out_Sat, Out_Valid, Out_Last, In_Ready, Cfg_Err, Done, Busy);
    end
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
  endtask

  task automatic test_basic;
    int d_before = done_cnt;
    q.delete();
    start_run(3, 1);
    load_tap(8'h01);
    load_tap(8'h00);
    load_tap(8'h03);
    for (int i = 1; i <= 5; i++) send(8'(i), i == 5);
    repeat (4) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 3) begin
      n_fail++;
      $display("FAIL basic_count: got %0d results, want 3", q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (q[i].d0 !== 8'hFE || q[i].last !== (i == 2)) begin
          n_fail++;
          $display("FAIL basic_result%0d: got %h last=%b, want fe last=%b", i, q[i].d0, q[i].last,
                   i == 2);
        end
      end
    end
    n_tests++;
    if (done_cnt != d_before + 1 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: got %0d pulses busy=%b, want 1 busy=0", done_cnt - d_before, Busy);
    end
    @(negedge Clk);
  endtask

  task automatic test_stride;
    int d_before = done_cnt;
    logic [7:0] exp_d [2];
    exp_d[0] = 8'd30;
    exp_d[1] = 8'd70;
    q.delete();
    start_run(2, 2);
    load_tap(8'h01);
    load_tap(8'h01);
    for (int i = 1; i <= 5; i++) send(8'(10 * i), i == 5);
    repeat (4) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 2) begin
      n_fail++;
      $display("FAIL stride_count: got %0d results, want 2", q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        n_tests++;
        if (q[i].d0 !== exp_d[i] || q[i].last !== 1'b0) begin
          n_fail++;
          $display("FAIL stride_result%0d: got %0d last=%b, want %0d last=0", i, q[i].d0,
                   q[i].last, exp_d[i]);
        end
      end
    end
    n_tests++;
    if (done_cnt != d_before + 1) begin
      n_fail++;
      $display("FAIL stride_done: got %0d pulses, want 1", done_cnt - d_before);
    end
    @(negedge Clk);
  endtask

  task automatic test_multi_ch;
    q.delete();
    start_run(4, 1);
    repeat (4) load_tap(8'h0D);
    for (int i = 5; i <= 8; i++) send(8'(i), i == 8);
    repeat (4) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 1) begin
      n_fail++;
      $display("FAIL multi_count: got %0d results, want 1", q.size());
    end else begin
      n_tests++;
      if (q[0].d0 !== 8'h1A || q[0].d1 !== 8'hE6 || q[0].last !== 1'b1) begin
        n_fail++;
        $display("FAIL multi_result: got ch0=%h ch1=%h last=%b, want 1a e6 1", q[0].d0, q[0].d1,
                 q[0].last);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    int d_before = done_cnt;
    q.delete();
    start_run(2, 1);
    load_tap(8'h01);
    load_tap(8'h01);
    fork
      begin
        for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
      end
      begin
        int g = 0;
        logic [7:0] hold;
        while (!Out_Valid && g < 50) begin
          @(negedge Clk);
          g++;
        end
        repeat (2) @(negedge Clk);
        Out_Ready = 1'b0;
        hold = Out_Data[7:0];
        for (int c = 0; c < 5; c++) begin
          @(negedge Clk);
          #1;
          n_tests++;
          if (Out_Data[7:0] !== hold || In_Ready !== 1'b0 || Out_Valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got data=%0d rdy=%b v=%b, want data=%0d rdy=0 v=1", c,
                     Out_Data[7:0], In_Ready, Out_Valid, hold);
          end
        end
        @(negedge Clk);
        Out_Ready = 1'b1;
      end
    join
    repeat (4) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 9) begin
      n_fail++;
      $display("FAIL stall_count: got %0d results, want 9", q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        n_tests++;
        if (q[i].d0 !== 8'(2 * i + 3) || q[i].last !== (i == 8)) begin
          n_fail++;
          $display("FAIL stall_result%0d: got %0d last=%b, want %0d last=%b", i, q[i].d0,
                   q[i].last, 2 * i + 3, i == 8);
        end
      end
    end
    n_tests++;
    if (done_cnt != d_before + 1) begin
      n_fail++;
      $display("FAIL stall_done: got %0d pulses, want 1", done_cnt - d_before);
    end
    @(negedge Clk);
  endtask

  task automatic test_overflow;
    logic [7:0] exp_d;
    logic       exp_s;
`ifdef SAM_CON_SAT_EN
    exp_d = 8'h7F;
    exp_s = 1'b1;
`else
    exp_d = 8'h90;
    exp_s = 1'b0;
`endif
    q.delete();
    start_run(4, 1);
    repeat (4) load_tap(8'h01);
    for (int i = 1; i <= 4; i++) send(8'd100, i == 4);
    repeat (4) @(negedge Clk);
    #1;
    n_tests++;
    if (q.size() != 1) begin
      n_fail++;
      $display("FAIL ovf_count: got %0d results, want 1", q.size());
    end else begin
      n_tests++;
      if (q[0].d0 !== exp_d || q[0].sat0 !== exp_s) begin
        n_fail++;
        $display("FAIL ovf_result: got %h sat=%b, want %h sat=%b", q[0].d0, q[0].sat0, exp_d,
                 exp_s);
      end
    end
    @(negedge Clk);
  endtask

  task automatic test_cfg_err;
    int ks [3];
    int ss [3];
    ks[0] = 0;  ss[0] = 1;
    ks[1] = 17; ss[1] = 1;
    ks[2] = 2;  ss[2] = 0;
    for (int i = 0; i < 3; i++) begin
      Start = 1'b1;
      Ksize_Cfg = CW'(ks[i]);
      Stride_Cfg = CW'(ss[i]);
      @(negedge Clk);
      Start = 1'b0;
      #1;
      n_tests++;
      if (Cfg_Err !== 1'b1 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_err%0d: got err=%b busy=%b, want err=1 busy=0", i, Cfg_Err, Busy);
      end
      @(negedge Clk);
      #1;
      n_tests++;
      if (Cfg_Err !== 1'b0 || Busy !== 1'b0) begin
        n_fail++;
        $display("FAIL cfg_pulse%0d: got err=%b busy=%b, want err=0 busy=0", i, Cfg_Err, Busy);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset_mid_run;
    start_run(2, 1);
    load_tap(8'h01);
    load_tap(8'h01);
    Out_Ready = 1'b0;
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    Rst = 1'b1;
    @(negedge Clk);
    #1;
    n_tests++;
    if ({Out_Data, Out_Sat, Out_Valid, Out_Last, In_Ready, Cfg_Err, Done, Busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_run: got data=%h v=%b rdy=%b busy=%b, want all 0", Out_Data,
               Out_Valid, In_Ready, Busy);
    end
    @(negedge Clk);
    Rst = 1'b0;
    Out_Ready = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stride();
    test_multi_ch();
    test_back_to_back();
    test_overflow();
    test_cfg_err();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound so a stuck handshake still ends the run.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation time bound reached");
    $fatal(1, "timeout");
  end

endmodule
